// File: rtl/regbank_access_ctrl_if.sv
// Requester and bank signal bundle for regbank_access_ctrl.
// slave  : the controller side (takes requests, drives the bank).
// master : the environment side (requesters plus the register bank).
interface regbank_access_ctrl_if;
   // writeback requester
   logic        wb_req;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_ack;
   // operand read requester
   logic        op_req;
   logic [4:0]  op_rs;
   logic [4:0]  op_rt;
   logic        op_ack;
   logic [31:0] op_data_1;
   logic [31:0] op_data_2;
   // debug read requester
   logic        dbg_req;
   logic [4:0]  dbg_rs;
   logic        dbg_ack;
   logic [31:0] dbg_data;
   // register bank
   logic [4:0]  rb_rs;
   logic [4:0]  rb_rt;
   logic [4:0]  rb_rd;
   logic        rb_write_reg;
   logic        rb_read_reg;
   logic [31:0] rb_write_data;
   logic [31:0] rb_data_1;
   logic [31:0] rb_data_2;
   // status
   logic        busy;

   modport slave (
      input  wb_req, wb_rd, wb_data,
      input  op_req, op_rs, op_rt,
      input  dbg_req, dbg_rs,
      input  rb_data_1, rb_data_2,
      output wb_ack, op_ack, op_data_1, op_data_2, dbg_ack, dbg_data,
      output rb_rs, rb_rt, rb_rd, rb_write_reg, rb_read_reg, rb_write_data,
      output busy
   );

   modport master (
      output wb_req, wb_rd, wb_data,
      output op_req, op_rs, op_rt,
      output dbg_req, dbg_rs,
      output rb_data_1, rb_data_2,
      input  wb_ack, op_ack, op_data_1, op_data_2, dbg_ack, dbg_data,
      input  rb_rs, rb_rt, rb_rd, rb_write_reg, rb_read_reg, rb_write_data,
      input  busy
   );
endinterface

// File: rtl/regbank_access_ctrl.sv
// Arbitrates one writeback port and two read ports (operand, debug) onto a
// single-ported register bank using one-cycle strobes.
// Ports: clk, reset (async active-high), bus (regbank_access_ctrl_if.slave).
// Latency: write ack 2 cycles after grant, read ack 3 cycles after grant.
// Backpressure: requests are held until acked; only sampled while idle.
module regbank_access_ctrl #(
   parameter bit DROP_R0_WRITES = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   regbank_access_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      WR_STROBE,
      WR_RELEASE,
      RD_STROBE,
      RD_CAPTURE,
      RD_RESP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic grant_wb;
   logic grant_op;
   logic grant_dbg;

   logic prefer_op;   // round-robin: 1 = op wins a tie with dbg
   logic rd_is_dbg;   // current read belongs to the debug port
   logic wr_en;       // current write actually reaches the bank

   // Next-state and grant decode. Writes always beat reads; between the two
   // read ports the last grant decides who goes first on a tie.
   always_comb begin
      state_nxt = state;
      grant_wb  = 1'b0;
      grant_op  = 1'b0;
      grant_dbg = 1'b0;
      case (state)
         IDLE: begin
            if (bus.wb_req) begin
               grant_wb  = 1'b1;
               state_nxt = WR_STROBE;
            end else if (bus.op_req && (prefer_op || !bus.dbg_req)) begin
               grant_op  = 1'b1;
               state_nxt = RD_STROBE;
            end else if (bus.dbg_req) begin
               grant_dbg = 1'b1;
               state_nxt = RD_STROBE;
            end
         end
         WR_STROBE:  state_nxt = WR_RELEASE;
         WR_RELEASE: state_nxt = IDLE;
         RD_STROBE:  state_nxt = RD_CAPTURE;
         RD_CAPTURE: state_nxt = RD_RESP;
         RD_RESP:    state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Bank address/data and result registers. Addresses are captured only on
   // the grant edge, so the requester may change its inputs afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.rb_rs         <= '0;
         bus.rb_rt         <= '0;
         bus.rb_rd         <= '0;
         bus.rb_write_data <= '0;
         bus.op_data_1     <= '0;
         bus.op_data_2     <= '0;
         bus.dbg_data      <= '0;
         prefer_op         <= 1'b1;
         rd_is_dbg         <= 1'b0;
         wr_en             <= 1'b0;
      end else begin
         if (grant_wb) begin
            bus.rb_rd         <= bus.wb_rd;
            bus.rb_write_data <= bus.wb_data;
            // r0 writes still walk the full write sequence, just unstrobed
            wr_en             <= !(DROP_R0_WRITES && (bus.wb_rd == 5'd0));
         end
         if (grant_op) begin
            bus.rb_rs <= bus.op_rs;
            bus.rb_rt <= bus.op_rt;
            rd_is_dbg <= 1'b0;
            prefer_op <= 1'b0;
         end
         if (grant_dbg) begin
            bus.rb_rs <= bus.dbg_rs;
            bus.rb_rt <= 5'd0;
            rd_is_dbg <= 1'b1;
            prefer_op <= 1'b1;
         end
         // bank data is valid in the cycle after the read strobe
         if (state == RD_CAPTURE) begin
            if (rd_is_dbg) begin
               bus.dbg_data <= bus.rb_data_1;
            end else begin
               bus.op_data_1 <= bus.rb_data_1;
               bus.op_data_2 <= bus.rb_data_2;
            end
         end
      end
   end

   // Strobes and acks decode from registered state only; each strobe state
   // lasts one cycle and is always followed by a non-strobe state.
   assign bus.rb_write_reg = (state == WR_STROBE) && wr_en;
   assign bus.rb_read_reg  = (state == RD_STROBE);
   assign bus.wb_ack       = (state == WR_RELEASE);
   assign bus.op_ack       = (state == RD_RESP) && !rd_is_dbg;
   assign bus.dbg_ack      = (state == RD_RESP) && rd_is_dbg;
   assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Self-checking bench for regbank_access_ctrl: directed vector table,
// multi-cycle arbitration/reset sequences, and random transactions checked
// against an array model of the register file.
module tb_regbank_access_ctrl;

   logic clk;
   logic reset;

   regbank_access_ctrl_if bus ();

   regbank_access_ctrl #(.DROP_R0_WRITES(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- register bank (environment) ----------------
   logic [31:0] bank [32];
   initial for (int i = 0; i < 32; i++) bank[i] = '0;
   always @(posedge clk) if (bus.rb_write_reg) bank[bus.rb_rd] <= bus.rb_write_data;
   assign bus.rb_data_1 = bank[bus.rb_rs];
   assign bus.rb_data_2 = bank[bus.rb_rt];

   // ---------------- reference model ----------------
   // Architectural register contents: r0 never changes.
   logic [31:0] ref_regs [32];
   logic [31:0] exp_op1, exp_op2, exp_dbg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- protocol monitor ----------------
   int   wr_pulses = 0;
   logic prev_wr = 1'b0, prev_rd = 1'b0, prev_busy = 1'b0;
   logic [4:0]  prev_rs, prev_rt, prev_rd_addr;
   logic [31:0] prev_wdata;
   always @(negedge clk) begin
      if (reset) begin
         prev_wr = 1'b0; prev_rd = 1'b0; prev_busy = 1'b0;
      end else begin
         chk("strobe_overlap", {31'd0, bus.rb_write_reg && bus.rb_read_reg}, 32'd0);
         chk("strobe_width", {31'd0, (bus.rb_write_reg && prev_wr) || (bus.rb_read_reg && prev_rd)}, 32'd0);
         if (bus.busy && prev_busy) begin
            chk("addr_hold", {bus.rb_rs, bus.rb_rt, bus.rb_rd}, {prev_rs, prev_rt, prev_rd_addr});
            chk("wdata_hold", bus.rb_write_data, prev_wdata);
         end
         if (bus.rb_write_reg) wr_pulses++;
         prev_wr = bus.rb_write_reg; prev_rd = bus.rb_read_reg; prev_busy = bus.busy;
         prev_rs = bus.rb_rs; prev_rt = bus.rb_rt; prev_rd_addr = bus.rb_rd;
         prev_wdata = bus.rb_write_data;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   function automatic logic ack_of(input int kind);
      case (kind)
         0:       return bus.wb_ack;
         1:       return bus.op_ack;
         default: return bus.dbg_ack;
      endcase
   endfunction

   // Issues one transaction and returns the latency in edges from the grant
   // edge to the edge that ends the ack cycle (-1 on timeout). Requester
   // inputs are scrambled right after the grant to prove they were latched.
   task automatic run_txn(input int kind, input logic [4:0] a, input logic [4:0] b,
                          input logic [31:0] d, output int lat);
      int g;
      lat = -1;
      g   = -1;
      @(negedge clk);
      case (kind)
         0: begin bus.wb_rd = a; bus.wb_data = d; bus.wb_req = 1'b1; end
         1: begin bus.op_rs = a; bus.op_rt = b; bus.op_req = 1'b1; end
         default: begin bus.dbg_rs = a; bus.dbg_req = 1'b1; end
      endcase
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.busy && g < 0) begin
            g = n;
            bus.wb_rd  = 5'($urandom); bus.wb_data = $urandom;
            bus.op_rs  = 5'($urandom); bus.op_rt   = 5'($urandom);
            bus.dbg_rs = 5'($urandom);
         end
         if (ack_of(kind)) begin
            lat = n - g + 1;
            break;
         end
      end
      bus.wb_req = 1'b0; bus.op_req = 1'b0; bus.dbg_req = 1'b0;
   endtask

   // Runs a transaction and checks it against the reference model.
   task automatic txn_checked(input int kind, input logic [4:0] a, input logic [4:0] b,
                              input logic [31:0] d);
      int lat;
      int p0;
      p0 = wr_pulses;
      run_txn(kind, a, b, d, lat);
      chk("latency", lat, (kind == 0) ? 2 : 3);
      if (kind == 0) begin
         chk("wr_pulses", wr_pulses - p0, (a != 5'd0) ? 1 : 0);
         if (a != 5'd0) ref_regs[a] = d;
      end else begin
         chk("rd_no_pulse", wr_pulses - p0, 0);
         if (kind == 1) begin
            exp_op1 = ref_regs[a];
            exp_op2 = ref_regs[b];
         end else begin
            exp_dbg = ref_regs[a];
         end
      end
      chk("op_data_1", bus.op_data_1, exp_op1);
      chk("op_data_2", bus.op_data_2, exp_op2);
      chk("dbg_data", bus.dbg_data, exp_dbg);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ctl"}, {26'd0, bus.rb_write_reg, bus.rb_read_reg, bus.wb_ack,
                          bus.op_ack, bus.dbg_ack, bus.busy}, 32'd0);
      chk({tag, "_op1"}, bus.op_data_1, 32'd0);
      chk({tag, "_op2"}, bus.op_data_2, 32'd0);
      chk({tag, "_dbg"}, bus.dbg_data, 32'd0);
      chk({tag, "_addr"}, {17'd0, bus.rb_rs, bus.rb_rt, bus.rb_rd}, 32'd0);
      chk({tag, "_wdata"}, bus.rb_write_data, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_op1 = '0; exp_op2 = '0; exp_dbg = '0;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int          kind;   // 0 write, 1 op read, 2 dbg read
      logic [4:0]  a;
      logic [4:0]  b;
      logic [31:0] d;
      logic [31:0] e1;     // op_data_1 (op) or dbg_data (dbg)
      logic [31:0] e2;     // op_data_2 (op)
      int          elat;
      int          epulse;
   } vec_t;

   vec_t vt [8];

   initial begin
      int lat;
      int p0;
      int seq[$];
      int rd_acks;

      vt[0] = '{0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        2, 1};
      vt[1] = '{1, 5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        3, 0};
      vt[2] = '{0, 5'd0,  5'd0,  32'h12345678, 32'h0,        32'h0,        2, 0};
      vt[3] = '{1, 5'd0,  5'd5,  32'h0,        32'h0,        32'hDEADBEEF, 3, 0};
      vt[4] = '{2, 5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        3, 0};
      vt[5] = '{0, 5'd31, 5'd0,  32'hA5A55A5A, 32'h0,        32'h0,        2, 1};
      vt[6] = '{1, 5'd31, 5'd5,  32'h0,        32'hA5A55A5A, 32'hDEADBEEF, 3, 0};
      vt[7] = '{2, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        3, 0};

      for (int i = 0; i < 32; i++) ref_regs[i] = '0;
      exp_op1 = '0; exp_op2 = '0; exp_dbg = '0;
      bus.wb_req = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
      bus.op_req = 1'b0; bus.op_rs = '0; bus.op_rt = '0;
      bus.dbg_req = 1'b0; bus.dbg_rs = '0;
      reset = 1'b1;
      #1;
      check_all_zero("por");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // table vectors: constant expectations, also fed into the model
      for (int i = 0; i < 8; i++) begin
         p0 = wr_pulses;
         run_txn(vt[i].kind, vt[i].a, vt[i].b, vt[i].d, lat);
         chk($sformatf("vec%0d_lat", i), lat, vt[i].elat);
         chk($sformatf("vec%0d_pulses", i), wr_pulses - p0, vt[i].epulse);
         if (vt[i].kind == 0) begin
            if (vt[i].a != 5'd0) ref_regs[vt[i].a] = vt[i].d;
         end else if (vt[i].kind == 1) begin
            exp_op1 = vt[i].e1; exp_op2 = vt[i].e2;
         end else begin
            exp_dbg = vt[i].e1;
         end
         chk($sformatf("vec%0d_op1", i), bus.op_data_1, exp_op1);
         chk($sformatf("vec%0d_op2", i), bus.op_data_2, exp_op2);
         chk($sformatf("vec%0d_dbg", i), bus.dbg_data, exp_dbg);
      end

      // all three together: expect wb, op, dbg; reads see the new write
      do_reset();
      seq.delete();
      @(negedge clk);
      bus.wb_rd = 5'd7; bus.wb_data = 32'h11112222; bus.wb_req = 1'b1;
      bus.op_rs = 5'd7; bus.op_rt = 5'd5; bus.op_req = 1'b1;
      bus.dbg_rs = 5'd7; bus.dbg_req = 1'b1;
      for (int n = 0; n < 40 && seq.size() < 3; n++) begin
         @(negedge clk);
         if (bus.wb_ack)  begin seq.push_back(0); bus.wb_req = 1'b0; end
         if (bus.op_ack)  begin seq.push_back(1); bus.op_req = 1'b0; end
         if (bus.dbg_ack) begin seq.push_back(2); bus.dbg_req = 1'b0; end
      end
      bus.wb_req = 1'b0; bus.op_req = 1'b0; bus.dbg_req = 1'b0;
      ref_regs[7] = 32'h11112222;
      chk("simul_count", seq.size(), 3);
      if (seq.size() == 3) chk("simul_order", {seq[0], seq[1], seq[2]}, {32'd0, 32'd1, 32'd2});
      exp_op1 = ref_regs[7]; exp_op2 = ref_regs[5]; exp_dbg = ref_regs[7];
      chk("simul_op1", bus.op_data_1, exp_op1);
      chk("simul_op2", bus.op_data_2, exp_op2);
      chk("simul_dbg", bus.dbg_data, exp_dbg);

      // held wb_req is served again before a waiting read
      seq.delete();
      p0 = wr_pulses;
      @(negedge clk);
      bus.wb_rd = 5'd9; bus.wb_data = 32'hCAFE0009; bus.wb_req = 1'b1;
      bus.op_rs = 5'd9; bus.op_rt = 5'd7; bus.op_req = 1'b1;
      for (int n = 0; n < 40 && seq.size() < 3; n++) begin
         @(negedge clk);
         if (bus.wb_ack) begin
            seq.push_back(0);
            if (seq.size() >= 2) bus.wb_req = 1'b0;
         end
         if (bus.op_ack) begin seq.push_back(1); bus.op_req = 1'b0; end
      end
      bus.wb_req = 1'b0; bus.op_req = 1'b0;
      ref_regs[9] = 32'hCAFE0009;
      chk("heldwb_count", seq.size(), 3);
      if (seq.size() == 3) chk("heldwb_order", {seq[0], seq[1], seq[2]}, {32'd0, 32'd0, 32'd1});
      chk("heldwb_pulses", wr_pulses - p0, 2);
      exp_op1 = ref_regs[9]; exp_op2 = ref_regs[7];
      chk("heldwb_op1", bus.op_data_1, exp_op1);

      // round-robin from reset with both reads held continuously
      do_reset();
      seq.delete();
      @(negedge clk);
      bus.op_rs = 5'd5; bus.op_rt = 5'd9; bus.op_req = 1'b1;
      bus.dbg_rs = 5'd31; bus.dbg_req = 1'b1;
      for (int n = 0; n < 60 && seq.size() < 4; n++) begin
         @(negedge clk);
         if (bus.op_ack)  seq.push_back(1);
         if (bus.dbg_ack) seq.push_back(2);
      end
      bus.op_req = 1'b0; bus.dbg_req = 1'b0;
      chk("rr_count", seq.size(), 4);
      if (seq.size() == 4) chk("rr_order", {seq[0], seq[1], seq[2], seq[3]},
                               {32'd1, 32'd2, 32'd1, 32'd2});
      exp_op1 = ref_regs[5]; exp_op2 = ref_regs[9]; exp_dbg = ref_regs[31];
      chk("rr_op1", bus.op_data_1, exp_op1);
      chk("rr_dbg", bus.dbg_data, exp_dbg);

      // reset during RD_CAPTURE aborts the read with no ack
      @(negedge clk);
      bus.op_rs = 5'd5; bus.op_rt = 5'd31; bus.op_req = 1'b1;
      begin
         bit seen;
         seen = 1'b0;
         for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (bus.rb_read_reg) seen = 1'b1;
         end
         chk("midrst_strobe_seen", {31'd0, seen}, 32'd1);
      end
      @(negedge clk);              // now in the capture cycle
      reset = 1'b1;
      #1;
      check_all_zero("midrst");
      bus.op_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      exp_op1 = '0; exp_op2 = '0; exp_dbg = '0;
      rd_acks = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (bus.op_ack || bus.dbg_ack || bus.wb_ack) rd_acks++;
      end
      chk("midrst_no_ack", rd_acks, 0);
      txn_checked(1, 5'd5, 5'd31, 32'h0);

      // random transactions against the model
      for (int i = 0; i < 120; i++) begin
         int k;
         k = $urandom_range(0, 2);
         txn_checked(k, 5'($urandom), 5'($urandom), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regbank_access_ctrl.md
REGBANK_ACCESS_CTRL -- requirements
Module: regbank_access_ctrl

Interface
REQ-001 The block SHALL have one parameter: DROP_R0_WRITES, default 1; when 1, writes to register 0 are acknowledged but never strobed into the bank.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; all logic is clocked on the rising edge of clk.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- wb_req  in  1  writeback write request, held until wb_ack
- wb_rd  in  5  write destination
- wb_data  in  32  write data
- wb_ack  out  1  one-cycle write completion pulse
- op_req  in  1  operand read request, held until op_ack
- op_rs  in  5  first source register
- op_rt  in  5  second source register
- op_ack  out  1  one-cycle read completion pulse
- op_data_1  out  32  registered value of op_rs
- op_data_2  out  32  registered value of op_rt
- dbg_req  in  1  debug read request, held until dbg_ack
- dbg_rs  in  5  debug source register
- dbg_ack  out  1  one-cycle debug completion pulse
- dbg_data  out  32  registered value of dbg_rs
- rb_rs  out  5  bank RS
- rb_rt  out  5  bank RT
- rb_rd  out  5  bank RD
- rb_write_reg  out  1  bank write strobe
- rb_read_reg  out  1  bank read strobe
- rb_write_data  out  32  bank write data
- rb_data_1  in  32  bank data_1
- rb_data_2  in  32  bank data_2
- busy  out  1  high whenever the state is not IDLE

Function
REQ-004 The FSM SHALL have six states: IDLE, WR_STROBE, WR_RELEASE, RD_STROBE, RD_CAPTURE and RD_RESP.
REQ-005 All outputs SHALL be registered or decoded from the state register only; no input-to-output combinational path.
REQ-006 In IDLE, priority SHALL be wb_req first, then reads; op_req and dbg_req arbitrate round-robin through a last-read-grant pointer that favours op after reset.
REQ-007 On a grant, the block SHALL latch the addresses and data into rb_rs/rb_rt/rb_rd/rb_write_data at that edge and hold them unchanged until the state returns to IDLE.
REQ-008 Write path: IDLE -> WR_STROBE (rb_write_reg=1) -> WR_RELEASE (rb_write_reg=0, wb_ack=1) -> IDLE; the ack occurs 2 cycles after the grant edge.
REQ-009 A write with wb_rd=0 and DROP_R0_WRITES=1 SHALL follow the same state sequence with rb_write_reg held 0.
REQ-010 Read path: IDLE -> RD_STROBE (rb_read_reg=1) -> RD_CAPTURE (rb_read_reg=0; rb_data_1/2 loaded into the output registers at the edge ending this state) -> RD_RESP (the granted ack=1) -> IDLE.
REQ-011 For a debug grant, the block SHALL drive rb_rs=dbg_rs and rb_rt=0, and only dbg_data is updated, from rb_data_1.
REQ-012 For an op grant, only op_data_1 and op_data_2 are updated.
REQ-013 Unupdated data outputs SHALL hold their values.
REQ-014 rb_write_reg and rb_read_reg SHALL never be high in the same cycle.
REQ-015 Each strobe SHALL be exactly one cycle wide and SHALL be followed by at least one low cycle.
REQ-016 Requests SHALL be sampled only in IDLE; requests arriving mid-transaction wait.
REQ-017 A requester that deasserts its request before the ack SHALL still receive the ack.
REQ-018 When all three requests arrive together, the service order SHALL be wb, op, dbg; a held wb_req is re-served before any read.

Reset
REQ-019 Reset SHALL force, asynchronously: state=IDLE; rb_write_reg=0; rb_read_reg=0; all acks=0; busy=0; op_data_1, op_data_2, dbg_data, rb_rs, rb_rt, rb_rd and rb_write_data to 0; round-robin pointer to op.
REQ-020 A reset asserted mid-transaction SHALL abort it with no ack; the bank contents are not affected by the controller.

Verification
REQ-021 Write then read: wb_req with rd=5 and data=0xDEADBEEF -> one rb_write_reg pulse and wb_ack 2 cycles after the grant; then op_req with rs=5 and rt=0 -> op_ack 3 cycles after the grant, op_data_1=0xDEADBEEF, op_data_2=0.
REQ-022 Simultaneous requests: wb, op and dbg asserted together -> acks in the order wb, op, dbg; the strobes never overlap.
REQ-023 Round-robin: op_req and dbg_req held high continuously -> grants alternate op, dbg, op, dbg.
REQ-024 Register-0 drop: wb_req with rd=0 and data=0x12345678 -> wb_ack pulses, no rb_write_reg pulse, and a later read of r0 returns 0.
REQ-025 Mid-read reset: reset asserted during RD_CAPTURE -> all outputs go to 0 immediately, no op_ack, and the next request completes normally.
REQ-026 Debug read: dbg_req with rs=5 after REQ-021 -> dbg_data=0xDEADBEEF, and op_data_1/op_data_2 are unchanged.
